// File: rtl/pea_token_fifo_pkg.sv
// Shared constants and helpers for the PEA token FIFO; pea_log2 matches the
// enable block's sizing so population/free_space widths line up with it.
package pea_token_fifo_pkg;

    // ceil(log2(n)) for n >= 1, usable in constant expressions
    function automatic int pea_log2(input int n);
        int r;
        r = 0;
        while ((1 << r) < n) r++;
        return r;
    endfunction

endpackage

// File: rtl/pea_fifo_ram.sv
// Simple dual-port storage: one synchronous write port, one registered read port.
module pea_fifo_ram
    import pea_token_fifo_pkg::*;
#(
    parameter int word_size   = 16,
    parameter int buffer_size = 1024
) (
    input  logic                             clk,
    input  logic                             rst,
    input  logic                             wr_en,
    input  logic [pea_log2(buffer_size)-1:0] wr_addr,
    input  logic [word_size-1:0]             wr_data,
    input  logic                             rd_en,
    input  logic [pea_log2(buffer_size)-1:0] rd_addr,
    output logic [word_size-1:0]             rd_data
);

    logic [word_size-1:0] mem [buffer_size];

    // storage is never reset; only the read register returns to zero
    always_ff @(posedge clk) begin
        if (wr_en) mem[wr_addr] <= wr_data;
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst)       rd_data <= '0;
        else if (rd_en) rd_data <= mem[rd_addr];
    end

endmodule

// File: rtl/pea_token_fifo.sv
// Single-clock token FIFO between PEA actors, exporting population/free_space
// for the enable logic threshold comparisons.
module pea_token_fifo
    import pea_token_fifo_pkg::*;
#(
    parameter int word_size   = 16,
    parameter int buffer_size = 1024
) (
    input  logic                             clk,
    input  logic                             rst,
    input  logic                             wr_en,
    input  logic [word_size-1:0]             wr_data,
    input  logic                             rd_en,
    output logic [word_size-1:0]             rd_data,
    output logic [pea_log2(buffer_size)-1:0] population,
    output logic [pea_log2(buffer_size)-1:0] free_space,
    output logic                             full,
    output logic                             empty,
    output logic                             overflow,
    output logic                             underflow
);

    localparam int AW = pea_log2(buffer_size);
    localparam logic [AW-1:0] CAP = AW'(buffer_size - 1);

    logic [AW-1:0] wr_ptr, rd_ptr, pop_cnt;
    logic          push_ok, pop_ok;

    // flags come straight from the registered count, so they track the post-edge value
    assign full       = (pop_cnt == CAP);
    assign empty      = (pop_cnt == '0);
    assign population = pop_cnt;
    assign free_space = CAP - pop_cnt;

    // empty blocks the pop and full blocks the push even when both are requested
    assign push_ok = wr_en && !full;
    assign pop_ok  = rd_en && !empty;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wr_ptr    <= '0;
            rd_ptr    <= '0;
            pop_cnt   <= '0;
            overflow  <= 1'b0;
            underflow <= 1'b0;
        end else begin
            if (push_ok) wr_ptr <= wr_ptr + 1'b1;
            if (pop_ok)  rd_ptr <= rd_ptr + 1'b1;
            if (push_ok && !pop_ok)      pop_cnt <= pop_cnt + 1'b1;
            else if (pop_ok && !push_ok) pop_cnt <= pop_cnt - 1'b1;
            if (wr_en && full)  overflow  <= 1'b1;
            if (rd_en && empty) underflow <= 1'b1;
        end
    end

    pea_fifo_ram #(
        .word_size   (word_size),
        .buffer_size (buffer_size)
    ) u_ram (
        .clk     (clk),
        .rst     (rst),
        .wr_en   (push_ok),
        .wr_addr (wr_ptr),
        .wr_data (wr_data),
        .rd_en   (pop_ok),
        .rd_addr (rd_ptr),
        .rd_data (rd_data)
    );

endmodule

// File: tb/tb_pea_token_fifo.sv
// Randomized + directed bench for pea_token_fifo against a queue-based model.
module tb_pea_token_fifo;

    localparam int WS  = 16;
    localparam int BS  = 8;
    localparam int CAP = BS - 1;

    logic          clk = 1'b0;
    logic          rst;
    logic          wr_en, rd_en;
    logic [WS-1:0] wr_data;
    logic [WS-1:0] rd_data;
    logic [2:0]    population, free_space;
    logic          full, empty, overflow, underflow;

    pea_token_fifo #(.word_size(WS), .buffer_size(BS)) dut (
        .clk        (clk),
        .rst        (rst),
        .wr_en      (wr_en),
        .wr_data    (wr_data),
        .rd_en      (rd_en),
        .rd_data    (rd_data),
        .population (population),
        .free_space (free_space),
        .full       (full),
        .empty      (empty),
        .overflow   (overflow),
        .underflow  (underflow)
    );

    always #5 clk = ~clk;

    logic [WS-1:0] q[$];
    logic [WS-1:0] m_rd;
    logic          m_ovf, m_unf;
    int            n_cmp = 0, n_err = 0, n_step = 0;
    bit            saw_dead = 0;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s step %0d: got %0h expected %0h", tag, n_step, got, exp);
        end
    endtask

    task automatic check_all();
        chk("population", 32'(population), 32'(q.size()));
        chk("free_space", 32'(free_space), 32'(CAP - q.size()));
        chk("full",       32'(full),       32'(q.size() == CAP));
        chk("empty",      32'(empty),      32'(q.size() == 0));
        chk("rd_data",    32'(rd_data),    32'(m_rd));
        chk("overflow",   32'(overflow),   32'(m_ovf));
        chk("underflow",  32'(underflow),  32'(m_unf));
        chk("invariant",  32'(population) + 32'(free_space), 32'(CAP));
    endtask

    task automatic model_reset();
        q.delete();
        m_rd  = '0;
        m_ovf = 1'b0;
        m_unf = 1'b0;
    endtask

    // called just after a negedge; applies one request and checks at the next negedge
    task automatic step(input logic we, input logic [WS-1:0] wd, input logic re);
        bit pu, po;
        wr_en = we; wr_data = wd; rd_en = re;
        pu = we && (q.size() < CAP);
        po = re && (q.size() > 0);
        if (we && !pu) m_ovf = 1'b1;
        if (re && !po) m_unf = 1'b1;
        @(posedge clk);
        if (po) m_rd = q.pop_front();
        if (pu) q.push_back(wd);
        @(negedge clk);
        wr_en = 1'b0; rd_en = 1'b0;
        n_step++;
        check_all();
        if (po && rd_data == 16'hDEAD) saw_dead = 1;
    endtask

    task automatic do_reset();
        rst = 1'b0;
        model_reset();
        @(negedge clk);
        check_all();
        rst = 1'b1;
    endtask

    initial begin
        rst = 1'b0; wr_en = 1'b0; rd_en = 1'b0; wr_data = '0;
        model_reset();
        repeat (2) @(negedge clk);
        check_all();
        rst = 1'b1;

        // fill to capacity, attempt one more, drain in order
        for (int i = 1; i <= CAP; i++) step(1'b1, WS'(i), 1'b0);
        chk("full_after_7", 32'(full), 32'd1);
        step(1'b1, 16'hDEAD, 1'b0);
        chk("ovf_after_8th", 32'(overflow), 32'd1);
        for (int i = 1; i <= CAP; i++) begin
            step(1'b0, '0, 1'b1);
            chk("drain_order", 32'(rd_data), 32'(i));
        end
        chk("no_dead", 32'(saw_dead), 32'd0);

        // pop on freshly reset FIFO
        do_reset();
        step(1'b0, '0, 1'b1);
        chk("unf_flag", 32'(underflow), 32'd1);
        chk("unf_rd",   32'(rd_data),   32'd0);

        // simultaneous push+pop while empty: push only
        do_reset();
        step(1'b1, 16'h00AA, 1'b1);
        chk("empty_pp_pop", 32'(population), 32'd1);

        // streaming at population 3 with wrap
        do_reset();
        for (int i = 0; i < 3; i++) step(1'b1, WS'(16'h100 + i), 1'b0);
        for (int i = 3; i < 23; i++) begin
            step(1'b1, WS'(16'h100 + i), 1'b1);
            chk("stream_pop", 32'(population), 32'd3);
            chk("stream_ord", 32'(rd_data), 32'(16'h100 + i - 3));
        end

        // full with simultaneous push+pop
        do_reset();
        for (int i = 0; i < CAP; i++) step(1'b1, WS'(16'h200 + i), 1'b0);
        step(1'b1, 16'hBEEF, 1'b1);
        chk("full_pp_pop", 32'(population), 32'd6);
        chk("full_pp_ovf", 32'(overflow), 32'd1);
        chk("full_pp_rd",  32'(rd_data), 32'h200);

        // asynchronous reset between edges
        do_reset();
        for (int i = 0; i < 4; i++) step(1'b1, WS'(16'h300 + i), 1'b0);
        #2 rst = 1'b0;
        #1;
        chk("async_pop",   32'(population), 32'd0);
        chk("async_empty", 32'(empty), 32'd1);
        chk("async_free",  32'(free_space), 32'd7);
        model_reset();
        @(negedge clk);
        rst = 1'b1;
        step(1'b1, 16'h5A5A, 1'b0);
        step(1'b0, '0, 1'b1);
        chk("post_rst_rt", 32'(rd_data), 32'h5A5A);

        // randomized traffic
        do_reset();
        for (int i = 0; i < 400; i++) begin
            int bias;
            bias = (i / 50) % 3;
            step(($urandom_range(0, 9) < (bias == 0 ? 8 : (bias == 1 ? 3 : 5))),
                 WS'($urandom), ($urandom_range(0, 9) < (bias == 1 ? 8 : (bias == 0 ? 3 : 5))));
            if ($urandom_range(0, 99) == 0) do_reset();
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
